// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer: debounces the four push-buttons and walks the user
// through entering operand A, operand B and an opcode from the switches,
// then offers the captured request downstream over a valid/ready handshake.
module key_entry_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 240_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        SW,
    input  logic [3:0]          KEY,
    output logic signed [N-1:0] a_out,
    output logic signed [N-1:0] b_out,
    output logic [3:0]          op_out,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [1:0]          stage,
    output logic                has_prev,
    output logic [7:0]          req_count,
    output logic [3:0]          key_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD,
        OP_AND, OP_OR, OP_XOR, OP_LSHIFT, OP_RSHIFT
    } opcode_t;

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        SEL_OP = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    logic [3:0]    sync1, sync2, level;
    logic [CW-1:0] cnt [4];

    state_t  state, state_next;
    opcode_t op_q;

    logic win_clear, win_commit, win_next, win_repeat;

    // Per-key synchronizer, stability counter and press-edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            level     <= '1;
            key_pulse <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= KEY;
            sync2     <= sync1;
            key_pulse <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != level[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        level[i]     <= sync2[i];
                        cnt[i]       <= '0;
                        key_pulse[i] <= ~sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Resolve simultaneous pulses: clear > commit > next > repeat.
    always_comb begin
        win_clear  = key_pulse[2];
        win_commit = key_pulse[0] & ~key_pulse[2];
        win_next   = key_pulse[1] & ~key_pulse[2] & ~key_pulse[0];
        win_repeat = key_pulse[3] & ~(|key_pulse[2:0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ISSUE ignores every key and waits for the transfer.
    always_comb begin
        state_next = state;
        case (state)
            GET_A: begin
                if (win_clear)                   state_next = GET_A;
                else if (win_commit)             state_next = GET_B;
                else if (win_repeat && has_prev) state_next = ISSUE;
            end
            GET_B: begin
                if (win_clear)       state_next = GET_A;
                else if (win_commit) state_next = SEL_OP;
            end
            SEL_OP: begin
                if (win_clear)       state_next = GET_A;
                else if (win_commit) state_next = ISSUE;
            end
            ISSUE: begin
                if (req_ready) state_next = GET_A;
            end
            default: state_next = GET_A;
        endcase
    end

    // Captured operands, opcode selection and transfer bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out     <= '0;
            b_out     <= '0;
            op_q      <= OP_ADD;
            req_count <= '0;
            has_prev  <= 1'b0;
        end else begin
            if (state == GET_A && win_commit) begin
                a_out <= SW;
            end
            if (state == GET_B && win_commit) begin
                b_out <= SW;
            end
            if (state == SEL_OP && win_next) begin
                op_q <= (op_q == OP_RSHIFT) ? OP_ADD : opcode_t'(op_q + 4'd1);
            end
            if (state == ISSUE && req_ready) begin
                req_count <= req_count + 8'd1;
                has_prev  <= 1'b1;
            end
        end
    end

    // Moore outputs.
    always_comb begin
        req_valid = (state == ISSUE);
        stage     = state;
        op_out    = op_q;
    end

endmodule

// File: doc/key_entry_sequencer.md
# key_entry_sequencer

Front-end operand-entry block for the board-level ALU demo. It debounces the four push-buttons and steps the user through entering operand A, operand B and an opcode from the switches. It then presents the captured request to the downstream ALU/result stage over a valid/ready handshake. It replaces the ad-hoc edge detection in the board top level with a single, verifiable sequencer.

## Interface

Parameters:
- `N` — default 4 — operand width.
- `DEBOUNCE_CYCLES` — default 240_000 (20 ms at 12 MHz) — required stable-level duration; minimum 2.

Ports:
- `clk` — in — 1 — single system clock.
- `rst_n` — in — 1 — reset, synchronous, active-low.
- `SW` — in — N — operand switches; sampled raw, no synchronizer required.
- `KEY` — in — 4 — push-buttons, active-low, asynchronous.
  - KEY[0]: commit.
  - KEY[1]: next opcode.
  - KEY[2]: clear.
  - KEY[3]: repeat.
- `a_out` — out — N, signed — captured operand A.
- `b_out` — out — N, signed — captured operand B.
- `op_out` — out — OpCode — selected opcode.
- `req_valid` — out — 1 — request valid.
- `req_ready` — in — 1 — downstream accepts.
- `stage` — out — 2 — current state, for LEDs: 0 GET_A, 1 GET_B, 2 SEL_OP, 3 ISSUE.
- `has_prev` — out — 1 — at least one request has been accepted since reset.
- `req_count` — out — 8 — accepted-request counter.
- `key_pulse` — out — 4 — debounced press pulses, for debug.

## Operation

Reset values (`rst_n` low at a clock edge):
- `a_out`, `b_out` = 0; `op_out` = Add.
- `req_valid` = 0; `stage` = GET_A.
- `has_prev` = 0; `req_count` = 0; `key_pulse` = 0.
- Debounced levels = 1 (released); debounce counters = 0.

Debounce (per key):
- 2-FF synchronizer, then a counter.
- Counter increments while the synchronized level differs from the debounced level; it clears to 0 on any cycle where they match.
- On reaching `DEBOUNCE_CYCLES`-1 with the mismatch still present, the debounced level flips.
- A 1→0 flip produces a one-cycle `key_pulse[i]`. Releases produce no pulse.

State machine (transitions on pulses):
- **GET_A**:
  - commit: `a_out` ← SW; go to GET_B.
  - repeat with `has_prev`=1: go to ISSUE with held A, B and op unchanged.
  - repeat with `has_prev`=0: ignored.
- **GET_B**:
  - commit: `b_out` ← SW; go to SEL_OP.
- **SEL_OP**:
  - next: `op_out` advances in OpCode declaration order Add, Sub, Mult, Div, Mod, And, Or, Xor, LShift, RShift; RShift wraps to Add.
  - commit: go to ISSUE.
- **ISSUE**:
  - `req_valid`=1.
  - On the cycle with `req_valid` && `req_ready`: `req_count`++ (wraps 255→0), `has_prev` ← 1, go to GET_A.
  - All key pulses are ignored, including clear.
- **clear**: in GET_A, GET_B or SEL_OP, go to GET_A. Captured registers are not modified.
- Next pulse in GET_A/GET_B and commit pulse in GET_A with no SW meaning beyond capture behave exactly as listed; all unlisted pulse/state pairs are ignored.

Rules:
- Simultaneous pulses: priority clear > commit > next > repeat. Only the winner acts; the others are discarded.
- `op_out` is not reset by clear or by returning to GET_A. The last opcode persists as the starting point for the next selection.

## Timing

- Key press latency:
  - Raw KEY[i] goes low before edge t and stays low.
  - Synchronized level differs from edge t+2.
  - `key_pulse[i]` is high for exactly the cycle after edge t+1+`DEBOUNCE_CYCLES`.
  - The resulting state/register update is visible after the following edge.
- A raw low shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no pulse.
- `req_valid` rises on the edge that enters ISSUE and stays high until the transfer cycle. It is low the cycle after the transfer.
- `a_out`, `b_out` and `op_out` are stable for the whole time `req_valid` is high.
- `req_ready` while `req_valid`=0 has no effect. `req_ready` held high gives a one-cycle ISSUE.
- Reset asserted mid-operation, including ISSUE with `req_valid` high, returns everything to reset values at that edge. No transfer is counted.

## Test plan

Run with `DEBOUNCE_CYCLES`=4.

1. Full entry path:
   - Stimulus: SW=3, commit; SW=-2 (4'b1110), commit; next ×2, commit; `req_ready` high.
   - Required: `a_out`=3, `b_out`=-2, `op_out`=Mult, one-cycle `req_valid`, `req_count`=1, `has_prev`=1, `stage` back to 0.
2. Bounce rejection:
   - Stimulus: KEY[0] low for 3 cycles, high 2, low 3.
   - Required: no `key_pulse`, `stage` stays 0. A subsequent 10-cycle low produces exactly one pulse at the specified latency.
3. Backpressure:
   - Stimulus: enter a request with `req_ready`=0 for 20 cycles; press clear and commit meanwhile; then assert `req_ready`.
   - Required: `req_valid` and operands unchanged throughout; transfer on the first ready cycle; `req_count`+1.
4. Opcode wrap and simultaneous keys:
   - Stimulus: in SEL_OP press next 10 times.
   - Required: `op_out` returns to its start value.
   - Stimulus: clear and commit pressed in the same cycle.
   - Required: go to GET_A, nothing captured.
5. Repeat:
   - Stimulus: repeat right after reset.
   - Required: ignored.
   - Stimulus: after one accepted request, repeat.
   - Required: ISSUE with identical A/B/op; `req_count`=2.
6. Reset in ISSUE:
   - Stimulus: `rst_n` low for one edge while `req_valid`=1.
   - Required: all outputs at reset values; `req_count` unchanged from 0.
   - Stimulus: `req_count` preloaded by 256 transfers.
   - Required: wraps to 0.
